fb_access_arbiter: RTL and testbench

//   Shares one single-port 160x120x12-bit framebuffer RAM between VGA scanout reads and

---
 rtl/fb_access_arbiter_if.sv | 33 +++
 rtl/fb_access_arbiter.sv | 145 ++++++++++++++
 tb/tb_fb_access_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_access_arbiter_if.sv
// rtl/fb_access_arbiter_if.sv - signal bundle between arbiter, timing generator, draw side and framebuffer RAM
interface fb_access_arbiter_if;
  logic        video_on;
  logic [9:0]  x;
  logic [9:0]  y;
  logic [11:0] rgb;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  wr_x;
  logic [6:0]  wr_y;
  logic [11:0] wr_data;
  logic        clr_start;
  logic [11:0] clr_color;
  logic        clr_busy;
  logic        wr_drop;
  logic        ram_en;
  logic        ram_we;
  logic [14:0] ram_addr;
  logic [11:0] ram_wdata;
  logic [11:0] ram_rdata;

  // arbiter side
  modport slave (
    input  video_on, x, y, wr_valid, wr_x, wr_y, wr_data, clr_start, clr_color, ram_rdata,
    output rgb, wr_ready, clr_busy, wr_drop, ram_en, ram_we, ram_addr, ram_wdata
  );

  // environment side: timing generator, draw engine and RAM
  modport master (
    output video_on, x, y, wr_valid, wr_x, wr_y, wr_data, clr_start, clr_color, ram_rdata,
    input  rgb, wr_ready, clr_busy, wr_drop, ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/fb_access_arbiter.sv
// rtl/fb_access_arbiter.sv - single-port framebuffer arbiter: scanout reads, buffered draw writes, clear sequencer
module fb_access_arbiter #(
  parameter int FB_W       = 160,
  parameter int FB_H       = 120,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk_100MHz,
  input  logic reset_n,
  fb_access_arbiter_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [14:0] LAST_ADDR = 15'(FB_W * FB_H - 1);
  localparam logic [7:0]  W_LIM     = 8'(FB_W);
  localparam logic [6:0]  H_LIM     = 7'(FB_H);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_CLEAR = 2'd2;

  // Linear pixel address; multiply by a constant reduces to (y<<7)+(y<<5) for a 160-wide buffer.
  function automatic logic [14:0] pix_addr(input logic [9:0] px, input logic [9:0] py);
    return 15'(py) * 15'(FB_W) + 15'(px);
  endfunction

  logic [1:0]    state;
  logic [14:0]   clr_addr;
  logic [11:0]   color_q;
  logic          ready_q;
  logic [9:0]    x_q, y_q;
  logic          rd_d1, rd_d2;

  logic [26:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;

  logic          full, empty, push, pop, scan_req, clr_go, head_ok;
  logic [26:0]   head;
  logic [7:0]    head_x;
  logic [6:0]    head_y;
  logic [11:0]   head_d;

  // Request decode and fixed priority: scanout, then clear, then FIFO head.
  always_comb begin
    full         = (count == (AW+1)'(FIFO_DEPTH));
    empty        = (count == '0);
    head         = fifo_mem[rptr];
    head_x       = head[26:19];
    head_y       = head[18:12];
    head_d       = head[11:0];
    head_ok      = (head_x < W_LIM) && (head_y < H_LIM);
    scan_req     = bus.video_on && ({bus.x, bus.y} != {x_q, y_q});
    clr_go       = !scan_req && (state == S_CLEAR);
    pop          = !scan_req && (state != S_CLEAR) && !empty;
    bus.wr_ready = ready_q && (state == S_IDLE) && !full;
    push         = bus.wr_valid && bus.wr_ready;
    bus.clr_busy = (state != S_IDLE);
  end

  // FIFO storage; contents need no reset because count gates every read.
  always_ff @(posedge clk_100MHz) begin
    if (push) fifo_mem[wptr] <= {bus.wr_x, bus.wr_y, bus.wr_data};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (!push && pop) count <= count - (AW+1)'(1);
    end
  end

  // Clear sequencer; ready_q delays wr_ready by one cycle on every return to IDLE.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      clr_addr <= '0;
      color_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      ready_q <= (state == S_IDLE);
      case (state)
        S_IDLE: begin
          if (bus.clr_start) begin
            color_q <= bus.clr_color;
            state   <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (empty) begin
            clr_addr <= '0;
            state    <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (clr_go) begin
            if (clr_addr == LAST_ADDR) state <= S_IDLE;
            else clr_addr <= clr_addr + 15'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Registered RAM port, scanout position tracking and pixel output pipeline.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      x_q           <= 10'h3FF;
      y_q           <= 10'h3FF;
      rd_d1         <= 1'b0;
      rd_d2         <= 1'b0;
      bus.rgb       <= '0;
      bus.wr_drop   <= 1'b0;
      bus.ram_en    <= 1'b0;
      bus.ram_we    <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_wdata <= '0;
    end else begin
      x_q         <= bus.x;
      y_q         <= bus.y;
      bus.ram_en  <= scan_req || clr_go || (pop && head_ok);
      bus.ram_we  <= !scan_req && (clr_go || (pop && head_ok));
      bus.wr_drop <= pop && !head_ok;
      if (scan_req) begin
        bus.ram_addr <= pix_addr(bus.x, bus.y);
      end else if (clr_go) begin
        bus.ram_addr  <= clr_addr;
        bus.ram_wdata <= color_q;
      end else if (pop && head_ok) begin
        bus.ram_addr  <= pix_addr({2'b00, head_x}, {3'b000, head_y});
        bus.ram_wdata <= head_d;
      end
      rd_d1 <= scan_req;
      rd_d2 <= rd_d1;
      if (!bus.video_on) bus.rgb <= '0;
      else if (rd_d2)    bus.rgb <= bus.ram_rdata;
    end
  end
endmodule

// File: tb/tb_fb_access_arbiter.sv
// tb/tb_fb_access_arbiter.sv - directed self-checking bench for fb_access_arbiter
module tb_fb_access_arbiter;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   scan_mode = 0;

  fb_access_arbiter_if bus();

  fb_access_arbiter dut (
    .clk_100MHz(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // 1-cycle synchronous framebuffer RAM model
  logic [11:0] mem [19200];
  always @(posedge clk) begin
    if (bus.ram_en && bus.ram_addr < 15'd19200) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      else bus.ram_rdata <= mem[bus.ram_addr];
    end
  end

  function automatic logic [14:0] a_of(input int xx, input int yy);
    return 15'(yy * 160 + xx);
  endfunction

  // Monitor: expected scanout slots and a log of every RAM write issued
  logic [26:0] wlog[$];
  bit          scan_exp = 1'b0;
  logic [14:0] scan_addr = '0;
  logic [9:0]  px = 10'h3FF, py = 10'h3FF;
  always @(negedge clk) begin
    if (!reset_n) begin
      scan_exp = 1'b0;
      px = 10'h3FF;
      py = 10'h3FF;
    end else begin
      if (scan_exp) begin
        n_checks++;
        if (bus.ram_en !== 1'b1 || bus.ram_we !== 1'b0 || bus.ram_addr !== scan_addr) begin
          n_fail++;
          $display("FAIL scan_slot: en=%b we=%b addr=%0d, required en=1 we=0 addr=%0d",
                   bus.ram_en, bus.ram_we, bus.ram_addr, scan_addr);
        end
      end
      if (bus.ram_en && bus.ram_we) wlog.push_back({bus.ram_addr, bus.ram_wdata});
      scan_exp  = bus.video_on && ({bus.x, bus.y} != {px, py});
      scan_addr = a_of(int'(bus.x), int'(bus.y));
      px = bus.x;
      py = bus.y;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (scan_mode == 1)      bus.x = 10'(cyc % 160);
    else if (scan_mode == 2) bus.x = 10'((cyc / 2) % 160);
  endtask

  task automatic do_write(input int wx, input int wy, input logic [11:0] d);
    int n;
    n = 0;
    bus.wr_valid = 1'b1;
    bus.wr_x = 8'(wx);
    bus.wr_y = 7'(wy);
    bus.wr_data = d;
    while (bus.wr_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    n_checks++;
    if (n >= 200) begin
      n_fail++;
      $display("FAIL wr_handshake: timeout for (%0d,%0d), required wr_ready within 200 cycles", wx, wy);
    end
    tick();
    bus.wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    scan_mode = 1;
    bus.video_on = 1'b1;
    bus.y = 10'd3;
    for (int i = 0; i < 6; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_x = 8'(40 + i);
      bus.wr_y = 7'd9;
      bus.wr_data = 12'h777;
      tick();
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.rgb, bus.wr_ready, bus.clr_busy, bus.wr_drop, bus.ram_en, bus.ram_we,
         bus.ram_addr, bus.ram_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: rgb=%h rdy=%b busy=%b drop=%b en=%b we=%b addr=%h wd=%h, required all 0",
               bus.rgb, bus.wr_ready, bus.clr_busy, bus.wr_drop, bus.ram_en, bus.ram_we,
               bus.ram_addr, bus.ram_wdata);
    end
    scan_mode = 0;
    bus.video_on = 1'b0;
    bus.wr_valid = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    wlog.delete();
    n_checks++;
    if (bus.wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_at_release: got %b required 0", bus.wr_ready);
    end
    tick();
    n_checks++;
    if (bus.wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_release: got %b required 1", bus.wr_ready);
    end
    for (int i = 0; i < 5; i++) tick();
    n_checks++;
    if (wlog.size() != 0) begin
      n_fail++;
      $display("FAIL fifo_flushed: %0d writes after reset, required 0", wlog.size());
    end
  endtask

  task automatic test_scanout();
    do_write(0, 0, 12'hF00);
    do_write(1, 0, 12'h0F0);
    for (int i = 0; i < 4; i++) tick();
    bus.x = 10'd5;
    bus.y = 10'd0;
    tick();
    bus.video_on = 1'b1;
    bus.x = 10'd0;
    tick();
    n_checks++;
    if (bus.ram_addr !== 15'd0 || bus.ram_en !== 1'b1 || bus.ram_we !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_addr0: addr=%0d en=%b we=%b, required 0/1/0", bus.ram_addr, bus.ram_en, bus.ram_we);
    end
    bus.x = 10'd1;
    tick();
    n_checks++;
    if (bus.ram_addr !== 15'd1 || bus.ram_en !== 1'b1) begin
      n_fail++;
      $display("FAIL fetch_addr1: addr=%0d en=%b, required 1/1", bus.ram_addr, bus.ram_en);
    end
    tick();
    n_checks++;
    if (bus.rgb !== 12'hF00) begin
      n_fail++;
      $display("FAIL rgb_pix0: got %h required f00", bus.rgb);
    end
    tick();
    n_checks++;
    if (bus.rgb !== 12'h0F0) begin
      n_fail++;
      $display("FAIL rgb_pix1: got %h required 0f0", bus.rgb);
    end
    bus.video_on = 1'b0;
    tick();
    n_checks++;
    if (bus.rgb !== 12'h000) begin
      n_fail++;
      $display("FAIL rgb_blank: got %h required 000", bus.rgb);
    end
  endtask

  task automatic test_writes_during_scan();
    wlog.delete();
    bus.y = 10'd0;
    bus.video_on = 1'b1;
    scan_mode = 2;
    for (int i = 0; i < 8; i++) do_write(10 + i, 5, 12'(12'h100 + i));
    bus.video_on = 1'b0;
    scan_mode = 0;
    for (int i = 0; i < 10; i++) tick();
    n_checks++;
    if (wlog.size() != 8) begin
      n_fail++;
      $display("FAIL stream_count: got %0d writes required 8", wlog.size());
    end
    for (int i = 0; i < 8 && i < wlog.size(); i++) begin
      n_checks++;
      if (wlog[i] !== {a_of(10 + i, 5), 12'(12'h100 + i)}) begin
        n_fail++;
        $display("FAIL stream_order[%0d]: got %h required %h", i, wlog[i], {a_of(10 + i, 5), 12'(12'h100 + i)});
      end
    end
    n_checks++;
    if (mem[a_of(17, 5)] !== 12'h107) begin
      n_fail++;
      $display("FAIL stream_mem: got %h required 107", mem[a_of(17, 5)]);
    end
  endtask

  task automatic test_fifo_full_drop();
    bus.video_on = 1'b1;
    scan_mode = 1;
    tick();
    tick();
    do_write(160, 0, 12'hAAA);
    do_write(20, 1, 12'h123);
    do_write(21, 1, 12'h124);
    do_write(22, 1, 12'h125);
    n_checks++;
    if (bus.wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_ready: got %b required 0", bus.wr_ready);
    end
    wlog.delete();
    bus.video_on = 1'b0;
    scan_mode = 0;
    tick();
    n_checks++;
    if (bus.wr_drop !== 1'b1 || bus.ram_en !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_pulse: drop=%b en=%b, required 1/0", bus.wr_drop, bus.ram_en);
    end
    tick();
    n_checks++;
    if (bus.wr_drop !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_width: got %b required 0", bus.wr_drop);
    end
    for (int i = 0; i < 5; i++) tick();
    n_checks++;
    if (wlog.size() != 3 || mem[a_of(20, 1)] !== 12'h123 || mem[a_of(22, 1)] !== 12'h125) begin
      n_fail++;
      $display("FAIL after_drop: writes=%0d m20=%h m22=%h, required 3/123/125",
               wlog.size(), mem[a_of(20, 1)], mem[a_of(22, 1)]);
    end
  endtask

  task automatic test_clear();
    int n, bad, rdy_bad;
    bus.video_on = 1'b1;
    scan_mode = 1;
    tick();
    tick();
    wlog.delete();
    do_write(30, 2, 12'h111);
    do_write(31, 2, 12'h222);
    bus.clr_color = 12'h00F;
    bus.clr_start = 1'b1;
    tick();
    bus.clr_start = 1'b0;
    bus.clr_color = 12'hFFF;
    n_checks++;
    if (bus.clr_busy !== 1'b1 || bus.wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_begin: busy=%b rdy=%b, required 1/0", bus.clr_busy, bus.wr_ready);
    end
    bus.video_on = 1'b0;
    scan_mode = 0;
    n = 0;
    rdy_bad = 0;
    while (bus.clr_busy === 1'b1 && n < 25000) begin
      if (bus.wr_ready !== 1'b0) rdy_bad++;
      tick();
      n++;
    end
    n_checks++;
    if (n >= 25000) begin
      n_fail++;
      $display("FAIL clr_timeout: clr_busy still %b after 25000 cycles, required 0", bus.clr_busy);
    end
    n_checks++;
    if (rdy_bad != 0) begin
      n_fail++;
      $display("FAIL clr_ready_low: wr_ready high %0d cycles while busy, required 0", rdy_bad);
    end
    n_checks++;
    if (bus.ram_en !== 1'b1 || bus.ram_we !== 1'b1 || bus.ram_addr !== 15'd19199 || bus.wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_fall: en=%b we=%b addr=%0d rdy=%b, required 1/1/19199/0",
               bus.ram_en, bus.ram_we, bus.ram_addr, bus.wr_ready);
    end
    tick();
    n_checks++;
    if (bus.wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_ready_rise: got %b required 1", bus.wr_ready);
    end
    n_checks++;
    if (wlog.size() != 19202 || wlog[0] !== {a_of(30, 2), 12'h111} || wlog[1] !== {a_of(31, 2), 12'h222}) begin
      n_fail++;
      $display("FAIL clr_sequence: count=%0d first=%h second=%h, required 19202/%h/%h",
               wlog.size(), wlog[0], wlog[1], {a_of(30, 2), 12'h111}, {a_of(31, 2), 12'h222});
    end
    bad = 0;
    for (int i = 0; i < 19200 && i + 2 < wlog.size(); i++)
      if (wlog[i + 2] !== {15'(i), 12'h00F}) bad++;
    for (int i = 0; i < 19200; i++)
      if (mem[i] !== 12'h00F) bad++;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL clr_fill: %0d bad entries, required 0", bad);
    end
  endtask

  task automatic test_reset_mid_clear();
    int n, bad;
    bus.clr_color = 12'h0A0;
    bus.clr_start = 1'b1;
    tick();
    bus.clr_start = 1'b0;
    n = 0;
    while (!(bus.ram_en === 1'b1 && bus.ram_we === 1'b1 && bus.ram_addr === 15'd5000) && n < 6000) begin
      tick();
      n++;
    end
    n_checks++;
    if (n >= 6000) begin
      n_fail++;
      $display("FAIL mid_clear_reach: address 5000 not reached, required within 6000 cycles");
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (bus.clr_busy !== 1'b0 || bus.ram_en !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_clear_abort: busy=%b en=%b, required 0/0", bus.clr_busy, bus.ram_en);
    end
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    n_checks++;
    if (bus.clr_busy !== 1'b0 || bus.wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_clear_idle: busy=%b rdy=%b, required 0/1", bus.clr_busy, bus.wr_ready);
    end
    n_checks++;
    if (mem[4999] !== 12'h0A0 || mem[5000] !== 12'h00F) begin
      n_fail++;
      $display("FAIL mid_clear_edge: m4999=%h m5000=%h, required 0a0/00f", mem[4999], mem[5000]);
    end
    bad = 0;
    for (int i = 0; i < 19200; i++)
      if (mem[i] !== ((i < 5000) ? 12'h0A0 : 12'h00F)) bad++;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL mid_clear_contents: %0d bad words, required 0", bad);
    end
  endtask

  initial begin
    bus.video_on = 1'b0;
    bus.x = 10'd0;
    bus.y = 10'd0;
    bus.wr_valid = 1'b0;
    bus.wr_x = 8'd0;
    bus.wr_y = 7'd0;
    bus.wr_data = 12'd0;
    bus.clr_start = 1'b0;
    bus.clr_color = 12'd0;
    bus.ram_rdata = 12'd0;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    test_reset();
    test_scanout();
    test_writes_during_scan();
    test_fifo_full_drop();
    test_clear();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
